// File: rtl/pipeline_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_hazard_ctrl
//
// Central stall/flush sequencer for the 5-stage RISC-V pipeline. It decides,
// every cycle, whether the PC and each pipeline register loads, holds, or is
// turned into a bubble. Three hazard sources are resolved by fixed priority:
// a data-memory access that has not completed, then a taken branch in EX,
// then a load-use dependency between EX and ID. After reset the pipeline is
// held drained for INIT_CYCLES clocks. Saturating stall and flush counters
// are kept for performance debug.
//
// Ports:
//   clk              pipeline clock, rising edge
//   rst              asynchronous, active-low reset
//   IF_ID_rs1/rs2    source registers of the instruction in ID
//   id_uses_rs2      the ID instruction reads rs2
//   ID_EX_rd         destination register of the instruction in EX
//   ID_EX_memread    the EX instruction is a load
//   ex_branch_taken  a branch/jump resolved taken in EX this cycle
//   mem_req          the MEM instruction accesses data memory
//   mem_ready        data memory completes the access this cycle
//   pc_write         PC update enable
//   IF_ID_write      IF_ID load enable
//   IF_ID_flush      IF_ID clear to NOP
//   ID_EX_write      ID_EX load enable
//   ID_EX_bubble     ID_EX loads NOP
//   EX_MEM_hold      EX_MEM keeps its contents
//   MEM_WB_bubble    MEM_WB loads NOP
//   mem_timeout      sticky: memory wait reached MEM_TIMEOUT cycles
//   stall_count      cycles with pc_write=0 outside INIT (saturating)
//   flush_count      taken-branch flush events (saturating)
// ---------------------------------------------------------------------------
module pipeline_hazard_ctrl #(
    parameter int INIT_CYCLES = 3,
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       IF_ID_rs1,
    input  logic [4:0]       IF_ID_rs2,
    input  logic             id_uses_rs2,
    input  logic [4:0]       ID_EX_rd,
    input  logic             ID_EX_memread,
    input  logic             ex_branch_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             IF_ID_write,
    output logic             IF_ID_flush,
    output logic             ID_EX_write,
    output logic             ID_EX_bubble,
    output logic             EX_MEM_hold,
    output logic             MEM_WB_bubble,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    typedef enum logic [1:0] {
        INIT     = 2'd0,
        RUN      = 2'd1,
        MEM_WAIT = 2'd2
    } state_t;

    localparam logic [3:0] INIT_LAST = 4'(INIT_CYCLES - 1);
    localparam logic [9:0] TIMEOUT_V = 10'(MEM_TIMEOUT);
    localparam logic [9:0] WAIT_MAX  = 10'd1023;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t           state_q, state_d;
    logic [3:0]       initCnt_q, initCnt_d;
    logic [9:0]       waitCnt_q, waitCnt_d;
    logic             memTimeout_q, memTimeout_d;
    logic [CNT_W-1:0] stallCnt_q, stallCnt_d;
    logic [CNT_W-1:0] flushCnt_q, flushCnt_d;

    logic loadUse;
    logic memStall;

    // A load in EX whose destination feeds the ID instruction needs one
    // bubble; x0 never creates a dependency. The memory stall term is the
    // outstanding, not-yet-completed data access in MEM.
    assign loadUse  = ID_EX_memread && (ID_EX_rd != 5'd0) &&
                      ((ID_EX_rd == IF_ID_rs1) ||
                       (id_uses_rs2 && (ID_EX_rd == IF_ID_rs2)));
    assign memStall = mem_req && !mem_ready;

    // State and bookkeeping registers. Reset drops straight back to INIT and
    // clears every counter and the sticky timeout, so nothing pending from
    // before reset can leak into the next run.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= INIT;
            initCnt_q    <= 4'd0;
            waitCnt_q    <= 10'd0;
            memTimeout_q <= 1'b0;
            stallCnt_q   <= '0;
            flushCnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            initCnt_q    <= initCnt_d;
            waitCnt_q    <= waitCnt_d;
            memTimeout_q <= memTimeout_d;
            stallCnt_q   <= stallCnt_d;
            flushCnt_q   <= flushCnt_d;
        end
    end

    // Next-state and output decode. Outputs default to the drained INIT
    // pattern. RUN and MEM_WAIT share one priority chain: while memory is
    // stalled everything upstream freezes and MEM_WB gets bubbles; in the
    // release cycle of MEM_WAIT the branch/load-use rules apply immediately,
    // so a branch held in EX across the wait is serviced (and counted) once.
    always_comb begin
        state_d       = state_q;
        initCnt_d     = initCnt_q;
        waitCnt_d     = waitCnt_q;
        memTimeout_d  = memTimeout_q;
        stallCnt_d    = stallCnt_q;
        flushCnt_d    = flushCnt_q;

        pc_write      = 1'b0;
        IF_ID_write   = 1'b0;
        IF_ID_flush   = 1'b1;
        ID_EX_write   = 1'b1;
        ID_EX_bubble  = 1'b1;
        EX_MEM_hold   = 1'b0;
        MEM_WB_bubble = 1'b1;

        case (state_q)
            INIT: begin
                if (initCnt_q == INIT_LAST) begin
                    state_d = RUN;
                end else begin
                    initCnt_d = initCnt_q + 4'd1;
                end
            end

            default: begin
                if (memStall) begin
                    pc_write      = 1'b0;
                    IF_ID_write   = 1'b0;
                    IF_ID_flush   = 1'b0;
                    ID_EX_write   = 1'b0;
                    ID_EX_bubble  = 1'b0;
                    EX_MEM_hold   = 1'b1;
                    MEM_WB_bubble = 1'b1;
                    state_d       = MEM_WAIT;
                    if (state_q == RUN) begin
                        waitCnt_d = 10'd1;
                    end else if (waitCnt_q != WAIT_MAX) begin
                        waitCnt_d = waitCnt_q + 10'd1;
                    end
                    if (waitCnt_d >= TIMEOUT_V) begin
                        memTimeout_d = 1'b1;
                    end
                end else begin
                    state_d       = RUN;
                    waitCnt_d     = 10'd0;
                    EX_MEM_hold   = 1'b0;
                    MEM_WB_bubble = 1'b0;
                    if (ex_branch_taken) begin
                        pc_write     = 1'b1;
                        IF_ID_write  = 1'b1;
                        IF_ID_flush  = 1'b1;
                        ID_EX_write  = 1'b1;
                        ID_EX_bubble = 1'b1;
                        if (flushCnt_q != CNT_MAX) begin
                            flushCnt_d = flushCnt_q + 1'b1;
                        end
                    end else if (loadUse) begin
                        pc_write     = 1'b0;
                        IF_ID_write  = 1'b0;
                        IF_ID_flush  = 1'b0;
                        ID_EX_write  = 1'b1;
                        ID_EX_bubble = 1'b1;
                    end else begin
                        pc_write     = 1'b1;
                        IF_ID_write  = 1'b1;
                        IF_ID_flush  = 1'b0;
                        ID_EX_write  = 1'b1;
                        ID_EX_bubble = 1'b0;
                    end
                end

                if (!pc_write && (stallCnt_q != CNT_MAX)) begin
                    stallCnt_d = stallCnt_q + 1'b1;
                end
            end
        endcase
    end

    // Bookkeeping values are presented straight from their registers.
    assign mem_timeout = memTimeout_q;
    assign stall_count = stallCnt_q;
    assign flush_count = flushCnt_q;

endmodule
